// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding, parity
// type constants and the oversampling sample/resolve index helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Edge indices within one bit period: three mid-bit sample points and the
  // edge at which their majority is valid.
  typedef struct packed {
    logic [5:0] s0;
    logic [5:0] s1;
    logic [5:0] s2;
    logic [5:0] res;
  } samp_idx_t;

  function automatic samp_idx_t samp_idx(input int unsigned os);
    samp_idx_t r;
    r.s0  = 6'(os / 2 - 1);
    r.s1  = 6'(os / 2);
    r.s2  = 6'(os / 2 + 1);
    r.res = 6'(os / 2 + 2);
    return r;
  endfunction

endpackage

// File: rtl/rx_bit_sampler.sv
// Per-bit timing for the UART receiver: counts oversampling edges within a
// bit, captures three mid-bit samples and majority-votes them.
//   CLK, RST     clock (OVERSAMPLE x baud), synchronous active-high reset
//   en           count enable; low clears edge_cnt so the next bit starts at 0
//   rx_s         synchronized serial line
//   sampled_bit  2-of-3 majority of the current bit (valid when resolve)
//   bit_done     last edge of the current bit period
//   resolve      edge at which sampled_bit is valid
module rx_bit_sampler
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = 8
) (
  input  logic CLK,
  input  logic RST,
  input  logic en,
  input  logic rx_s,
  output logic sampled_bit,
  output logic bit_done,
  output logic resolve
);

  localparam int unsigned     CW   = $clog2(OVERSAMPLE);
  localparam samp_idx_t       IDX  = samp_idx(OVERSAMPLE);
  localparam logic [CW-1:0]   LAST = CW'(OVERSAMPLE - 1);

  logic [CW-1:0] edge_cnt;
  logic [2:0]    samples;

  // Edge counter and mid-bit sample capture
  always_ff @(posedge CLK) begin
    if (RST) begin
      edge_cnt <= '0;
      samples  <= '0;
    end else begin
      if (!en)                   edge_cnt <= '0;
      else if (edge_cnt == LAST) edge_cnt <= '0;
      else                       edge_cnt <= edge_cnt + CW'(1);

      if (edge_cnt == CW'(IDX.s0)) samples[0] <= rx_s;
      if (edge_cnt == CW'(IDX.s1)) samples[1] <= rx_s;
      if (edge_cnt == CW'(IDX.s2)) samples[2] <= rx_s;
    end
  end

  assign sampled_bit = (samples[0] & samples[1]) |
                       (samples[0] & samples[2]) |
                       (samples[1] & samples[2]);
  assign resolve     = (edge_cnt == CW'(IDX.res));
  assign bit_done    = (edge_cnt == LAST);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: recovers start/data/parity/stop frames from the serial line
// and presents each good byte on p_data with a one-cycle data_valid strobe.
//   CLK, RST    clock (OVERSAMPLE x baud), synchronous active-high reset
//   rx_in       asynchronous serial input, idles high
//   par_en      frame carries a parity bit (latched at start of frame)
//   par_typ     0 = even, 1 = odd parity (latched at start of frame)
//   p_data      last error-free word, held until the next good frame
//   data_valid  one-cycle strobe, p_data just updated
//   par_err     one-cycle strobe, parity mismatch
//   stp_err     one-cycle strobe, stop bit sampled low
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = 8,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  rx_in,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic [DATA_WIDTH-1:0] p_data,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);

  localparam int unsigned   BW       = $clog2(DATA_WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  logic                  rx_meta;
  logic                  rx_s;
  rx_state_t             state;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shift;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic                  par_bad;

  logic sampled_bit;
  logic bit_done;
  logic resolve;
  logic fin_c;
  logic en_c;
  logic exp_par_c;

  // Two-flop synchronizer; idles high so reset does not look like a start bit
  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rx_s    <= rx_meta;
    end
  end

  // Frame ends at the resolve edge of a glitched start bit or of the stop bit.
  // The edge counter is cleared in that cycle so IDLE can restart at once.
  assign fin_c     = resolve && (((state == START) && sampled_bit) || (state == STOP));
  assign en_c      = (state == IDLE) ? !rx_s : !fin_c;
  assign exp_par_c = (^shift) ^ (par_typ_q == PAR_ODD);

  rx_bit_sampler #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_sampler (
    .CLK         (CLK),
    .RST         (RST),
    .en          (en_c),
    .rx_s        (rx_s),
    .sampled_bit (sampled_bit),
    .bit_done    (bit_done),
    .resolve     (resolve)
  );

  // Frame FSM, shift register and registered result strobes
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shift      <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= PAR_EVEN;
      par_bad    <= 1'b0;
      p_data     <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state     <= START;
            par_en_q  <= par_en;
            par_typ_q <= par_typ ? PAR_ODD : PAR_EVEN;
            par_bad   <= 1'b0;
            bit_cnt   <= '0;
          end
        end
        START: begin
          if (resolve && sampled_bit) state <= IDLE;
          else if (bit_done)          state <= DATA;
        end
        DATA: begin
          if (resolve) shift <= {sampled_bit, shift[DATA_WIDTH-1:1]};
          if (bit_done) begin
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              state   <= par_en_q ? PARITY : STOP;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
            end
          end
        end
        PARITY: begin
          if (resolve)  par_bad <= (sampled_bit != exp_par_c);
          if (bit_done) state   <= STOP;
        end
        STOP: begin
          // Evaluate at the resolve edge; no wait for the end of the stop bit
          if (resolve) begin
            state <= IDLE;
            if (par_bad || !sampled_bit) begin
              par_err <= par_bad;
              stp_err <= !sampled_bit;
            end else begin
              p_data     <= shift;
              data_valid <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;
  import uart_pkg::*;

  localparam int unsigned OS = 8;
  localparam int unsigned DW = 8;
  localparam int unsigned H  = OS / 2;

  logic          CLK = 1'b0;
  logic          RST;
  logic          rx_in;
  logic          par_en;
  logic          par_typ;
  logic [DW-1:0] p_data;
  logic          data_valid;
  logic          par_err;
  logic          stp_err;

  uart_rx #(.OVERSAMPLE(OS), .DATA_WIDTH(DW)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .rx_in      (rx_in),
    .par_en     (par_en),
    .par_typ    (par_typ),
    .p_data     (p_data),
    .data_valid (data_valid),
    .par_err    (par_err),
    .stp_err    (stp_err)
  );

  always #5 CLK = ~CLK;

  // One entry per clock cycle of line stimulus
  typedef struct { bit rx; bit pen; bit ptyp; bit rst; } cyc_t;
  // One entry per transmitted frame (or start glitch)
  typedef struct { int p; int nstop; bit glitch; logic [DW-1:0] data; bit pe; bit se; } frm_t;
  // One entry per strobe cycle
  typedef struct { int cyc; logic dv; logic pe; logic se; logic [DW-1:0] pd; } ev_t;

  cyc_t wave[$];
  frm_t frames[$];
  ev_t  exp_q[$];
  ev_t  obs_q[$];
  int   idle_q[$];
  int   zero_q[$];

  int            errors = 0;
  int            checks = 0;
  logic [DW-1:0] model_pd = '0;

  task automatic new_phase();
    wave = {}; frames = {}; exp_q = {}; idle_q = {}; zero_q = {};
  endtask

  task automatic add_idle(input int n);
    for (int j = 0; j < n; j++)
      wave.push_back('{rx: 1'b1, pen: 1'($urandom), ptyp: 1'($urandom), rst: 1'b0});
  endtask

  task automatic add_glitch(input int len);
    int p;
    p = wave.size();
    for (int j = 0; j < len; j++)
      wave.push_back('{rx: 1'b0, pen: 1'($urandom), ptyp: 1'($urandom), rst: 1'b0});
    frames.push_back('{p: p, nstop: 0, glitch: 1'b1, data: '0, pe: 1'b0, se: 1'b0});
  endtask

  // per = bit period in hundredths of a clock cycle (800 nominal, 784 = 2% fast)
  task automatic add_frame(input logic [DW-1:0] data, input bit pen, input bit ptyp,
                           input bit flip, input bit stop_bit, input int per);
    bit b[$];
    int p;
    int nb;
    b.push_back(1'b0);
    for (int j = 0; j < DW; j++) b.push_back(data[j]);
    if (pen) b.push_back((^data) ^ ptyp ^ flip);
    b.push_back(stop_bit);
    nb = b.size();
    p  = wave.size();
    for (int j = 0; (j * 100) / per < nb; j++)
      wave.push_back('{rx: b[(j * 100) / per], pen: 1'($urandom), ptyp: 1'($urandom), rst: 1'b0});
    // parity controls only need to be valid around start detection
    for (int j = 0; j < 6; j++) begin
      wave[p + j].pen  = pen;
      wave[p + j].ptyp = ptyp;
    end
    frames.push_back('{p: p, nstop: nb - 1, glitch: 1'b0, data: data,
                       pe: pen && (b[nb - 2] != ((^data) ^ ptyp)), se: !stop_bit});
  endtask

  // Expected strobes: start seen 2 cycles after the line falls (or once the
  // receiver is back in IDLE), strobe at stop-bit index * OS + H + 3.
  task automatic predict();
    int ready;
    int t0;
    logic good;
    ready = 0;
    foreach (frames[k]) begin
      t0 = (frames[k].p + 2 > ready) ? frames[k].p + 2 : ready;
      if (frames[k].glitch) begin
        ready = t0 + int'(H) + 3;
        idle_q.push_back(ready);
      end else begin
        ready = t0 + frames[k].nstop * int'(OS) + int'(H) + 3;
        good  = !frames[k].pe && !frames[k].se;
        if (good) model_pd = frames[k].data;
        exp_q.push_back('{cyc: ready, dv: good, pe: frames[k].pe, se: frames[k].se, pd: model_pd});
      end
    end
  endtask

  task automatic play(input string tag);
    ev_t o;
    predict();
    obs_q = {};
    for (int i = 0; i < wave.size(); i++) begin
      @(negedge CLK);
      if (data_valid || par_err || stp_err) begin
        o = '{cyc: i, dv: data_valid, pe: par_err, se: stp_err, pd: p_data};
        obs_q.push_back(o);
      end
      if (idle_q.size() != 0 && idle_q[0] == i) begin
        void'(idle_q.pop_front());
        checks++;
        assert (dut.state === IDLE) else begin
          errors++; $error("FAIL %s idle state @%0d: got %0d expected %0d", tag, i, dut.state, IDLE);
        end
      end
      if (zero_q.size() != 0 && zero_q[0] == i) begin
        void'(zero_q.pop_front());
        checks++;
        assert ({p_data, data_valid, par_err, stp_err} === (DW + 3)'(0)) else begin
          errors++; $error("FAIL %s reset outputs @%0d: got %0h expected 0", tag, i,
                           {p_data, data_valid, par_err, stp_err});
        end
      end
      RST     = wave[i].rst;
      rx_in   = wave[i].rx;
      par_en  = wave[i].pen;
      par_typ = wave[i].ptyp;
    end
    RST = 1'b0;
    checks++;
    assert (idle_q.size() == 0 && zero_q.size() == 0) else begin
      errors++; $error("FAIL %s pending checks: got %0d expected 0", tag, idle_q.size() + zero_q.size());
    end
    checks++;
    assert (obs_q.size() === exp_q.size()) else begin
      errors++; $error("FAIL %s strobe count: got %0d expected %0d", tag, obs_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      checks++;
      assert (obs_q[k].cyc === exp_q[k].cyc) else begin
        errors++; $error("FAIL %s[%0d] strobe cycle: got %0d expected %0d", tag, k, obs_q[k].cyc, exp_q[k].cyc);
      end
      checks++;
      assert ({obs_q[k].dv, obs_q[k].pe, obs_q[k].se} === {exp_q[k].dv, exp_q[k].pe, exp_q[k].se}) else begin
        errors++; $error("FAIL %s[%0d] dv/pe/se: got %b%b%b expected %b%b%b", tag, k,
                         obs_q[k].dv, obs_q[k].pe, obs_q[k].se, exp_q[k].dv, exp_q[k].pe, exp_q[k].se);
      end
      checks++;
      assert (obs_q[k].pd === exp_q[k].pd) else begin
        errors++; $error("FAIL %s[%0d] p_data: got %0h expected %0h", tag, k, obs_q[k].pd, exp_q[k].pd);
      end
    end
  endtask

  initial begin
    int            r;
    logic [DW-1:0] d;
    bit            pen;
    bit            pt;
    bit            flip;
    bit            stp;

    RST = 1'b1; rx_in = 1'b1; par_en = 1'b0; par_typ = 1'b0;
    repeat (3) @(negedge CLK);
    checks++;
    assert ({p_data, data_valid, par_err, stp_err} === (DW + 3)'(0)) else begin
      errors++; $error("FAIL reset outputs: got %0h expected 0", {p_data, data_valid, par_err, stp_err});
    end
    checks++;
    assert (dut.state === IDLE) else begin
      errors++; $error("FAIL reset state: got %0d expected %0d", dut.state, IDLE);
    end
    RST = 1'b0;

    new_phase();
    add_idle(10); add_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 800); add_idle(20);
    play("8n1");

    new_phase();
    add_idle(10);
    add_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 800); add_idle(5);
    add_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 800); add_idle(5);
    add_frame(8'hC3, 1'b1, 1'b1, 1'b0, 1'b1, 800); add_idle(5);
    add_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 800); add_idle(20);
    play("parity");

    new_phase();
    add_idle(10); add_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 800); add_idle(20);
    play("framing");

    new_phase();
    add_idle(10); add_glitch(2); add_idle(20);
    add_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 800); add_idle(20);
    play("glitch");

    new_phase();
    add_idle(10);
    add_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 784);
    add_frame(8'hAA, 1'b0, 1'b0, 1'b0, 1'b1, 784);
    add_idle(20);
    play("b2b");

    // reset in the middle of data bit 4 of 0xFF, then a clean 0x12 frame
    new_phase();
    add_idle(10);
    add_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 800);
    r = frames[frames.size() - 1].p + 5 * int'(OS) + 4;
    void'(frames.pop_back());
    wave[r].rst = 1'b1;
    idle_q.push_back(r + 1);
    zero_q.push_back(r + 1);
    add_idle(10); add_frame(8'h12, 1'b0, 1'b0, 1'b0, 1'b1, 800); add_idle(20);
    model_pd = '0;
    play("rst");

    new_phase();
    add_idle(10);
    for (int k = 0; k < 24; k++) begin
      d    = DW'($urandom);
      pen  = 1'($urandom);
      pt   = 1'($urandom);
      flip = ($urandom_range(0, 3) == 0);
      stp  = ($urandom_range(0, 7) != 0);
      add_frame(d, pen, pt, flip, stp, 800);
      add_idle(stp ? int'($urandom_range(0, 6)) : 10);
    end
    add_idle(20);
    play("rand");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receive end of the UART link: recovers frames sent by the team's UART transmitter and presents each byte as a parallel word with a one-cycle valid strobe. Frame format is 1 start bit (0), DATA_WIDTH data bits LSB first, an optional parity bit, and 1 stop bit (1). The block runs on a clock at OVERSAMPLE × baud, majority-votes three mid-bit samples per bit, and flags parity and stop-bit errors. It sits between the RX pad and the byte consumer (FIFO or register file).

## Interface
- OVERSAMPLE, 8: CLK cycles per bit period. Legal values are 8, 16 and 32.
- DATA_WIDTH, 8: data bits per frame. Legal range is 5 to 9.
- CLK  in  1  clock at OVERSAMPLE × baud.
- RST  in  1  reset, synchronous, active-high.
- rx_in  in  1  asynchronous serial line; idles high.
- par_en  in  1  1 = the frame carries a parity bit.
- par_typ  in  1  parity type: 0 = even, 1 = odd.
- p_data  out  DATA_WIDTH  last received word.
- data_valid  out  1  one-cycle strobe: p_data holds a new error-free word.
- par_err  out  1  one-cycle strobe: parity mismatch.
- stp_err  out  1  one-cycle strobe: stop bit sampled as 0.

## Operation
- **Input synchronizer:** rx_in passes through two flops before any logic uses it. Both flops reset to 1. The synchronized signal is called rx_s.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
- **Per-bit counters:**
  - edge_cnt counts 0 to OVERSAMPLE−1 within a bit.
  - bit_cnt counts data bits.
  - When edge_cnt reaches OVERSAMPLE−1 it wraps to 0 and the FSM advances to the next bit.
- **Sampling:**
  - rx_s is sampled at edge_cnt = H−1, H and H+1, where H = OVERSAMPLE/2.
  - The bit value is the 2-of-3 majority, resolved at edge_cnt = H+2.
- **IDLE:**
  - The first cycle with rx_s = 0 is edge 0 of the start bit. The FSM moves to START with edge_cnt = 1.
  - par_en and par_typ are latched in this same cycle and used for the whole frame. Changes to them mid-frame are ignored.
- **START:** at the resolve edge, a vote of 1 means a glitch. The FSM returns to IDLE and no strobe is issued. Otherwise START runs to the end of the bit, then goes to DATA.
- **DATA:** each resolved bit shifts in LSB first. After DATA_WIDTH bits the FSM goes to PARITY if par_en is latched to 1, otherwise to STOP.
- **PARITY:** expected bit = XOR of the data bits, XOR par_typ. A mismatch is recorded and reported at the end of STOP.
- **STOP:** at the resolve edge the FSM evaluates the frame, then returns to IDLE on the next cycle. It does not wait for the end of the stop bit, so back-to-back frames and a slightly fast transmitter are tolerated. Outputs, registered on that transition:
  - No error: p_data ← shift register, data_valid = 1.
  - Error: par_err and/or stp_err = 1, data_valid = 0, and p_data is left unchanged.
- **Strobes:** all strobes are exactly one cycle wide.
- **Reset values:** p_data = 0, data_valid = 0, par_err = 0, stp_err = 0, FSM = IDLE, all counters = 0, shift register = 0.
- **Reset mid-frame:** the frame is aborted in the cycle after RST is sampled high, and no strobe is issued.

## Timing
- Let P be the CLK cycle in which rx_in falls. rx_s goes low at T0 = P+2.
- Edge e of bit k (start bit is k = 0) occurs at cycle T0 + k·OVERSAMPLE + e.
- Let N = 1 + DATA_WIDTH + par_en. This is the stop-bit index.
- Strobes are high at cycle T0 + N·OVERSAMPLE + H + 3.
  - OVERSAMPLE = 8, 8N1: strobe at P+81.
  - OVERSAMPLE = 8, 8E1: strobe at P+89.
- IDLE is re-entered in the strobe cycle. A start edge can be detected from that cycle onward.
- Start-glitch rejection: a low pulse shorter than 2 of the 3 sample points returns the FSM to IDLE at T0 + H + 3.
- There is no backpressure. The consumer must capture p_data when data_valid is high; p_data holds until the next good frame.

## Structure
- **uart_pkg (shared package):**
  - FSM state enum.
  - Parity-type constants (PAR_EVEN = 0, PAR_ODD = 1).
  - Function returning the sample and resolve indices for a given OVERSAMPLE.
- **Sub-module rx_bit_sampler:**
  - Contains edge_cnt, the 3-sample majority vote and the resolve strobe.
  - Ports: CLK, RST, en, rx_s, sampled_bit, bit_done, resolve.
- **uart_rx top:** contains the synchronizer, FSM, bit counter, shift register, parity check and output registers.

## Test plan
- **8N1 single frame:** OVERSAMPLE = 8, send 0xA5 with par_en = 0 → p_data = 0xA5 and data_valid high for exactly one cycle at P+81. par_err and stp_err stay 0.
- **8E1 parity:** send 0x3C with correct parity bit 0 → data_valid at P+89. Send 0x3C with parity bit 1 → par_err pulse, data_valid = 0, p_data unchanged. Repeat with odd parity (par_typ = 1).
- **Framing error:** send 0x5A with stop bit driven 0 → stp_err pulse at P+81, no data_valid.
- **Start glitch:**
  - rx_in low for 2 cycles → no strobe, FSM back in IDLE.
  - A following valid 0x81 frame is received correctly.
- **Back-to-back frames:** send 0x55 then 0xAA with no idle gap and the transmitter running 2% fast → two data_valid pulses carrying 0x55 then 0xAA.
- **Reset mid-frame:** assert RST at data bit 4 of 0xFF → all outputs are 0 and the FSM is IDLE the next cycle. A following 0x12 frame is received correctly.
